// File: rtl/cmd_frame_rx_pkg.sv
// Shared command-path types and constants for the UART command framing stage.
package cmd_frame_rx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 16;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } rx_state_t;

  typedef enum logic {
    R_IDLE,
    R_BUSY
  } tx_state_t;

  // Response bytes and command opcodes (opcode lives in the high nibble of the high byte)
  localparam logic [BYTE_W-1:0] POS_ACK  = 8'hA5;
  localparam logic [CMD_W-1:0]  CAL_GYRO = 16'h2000;
  localparam logic [CMD_W-1:0]  MOVE     = 16'h4000;
  localparam logic [CMD_W-1:0]  TOUR     = 16'h6000;

  function automatic logic [CMD_W-1:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/cmd_frame_rx_timeout_cnt.sv
// Loadable inter-byte timeout counter; tc_c flags the last allowed cycle.
module frame_timeout_cnt #(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == CNT_W'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/cmd_frame_rx.sv
// Two-byte command framer with inter-byte timeout, plus single-byte response serializer.
module cmd_frame_rx
  import cmd_frame_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  output logic              frame_err,
  input  logic [BYTE_W-1:0] resp,
  input  logic              send_resp,
  output logic [BYTE_W-1:0] tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              resp_busy
);

  rx_state_t         rx_state, rx_state_nxt;
  tx_state_t         tx_state, tx_state_nxt;
  logic [BYTE_W-1:0] hi_byte, hi_byte_nxt;
  logic [CMD_W-1:0]  cmd_nxt;
  logic              cmd_rdy_nxt;
  logic              frame_err_nxt;
  logic [BYTE_W-1:0] tx_data_nxt;
  logic              trmt_nxt;
  logic              resp_busy_nxt;
  logic              accept_c;
  logic              cnt_load;
  logic              cnt_en;
  logic              timeout_c;

  // The cycle after an accept carries clr_rx_rdy, so a still-high rx_rdy is not re-captured
  assign accept_c = rx_rdy & ~clr_rx_rdy;

  frame_timeout_cnt #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .CNT_W        (CNT_W)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc_c (timeout_c)
  );

  // Receive framing: next state and registered output values
  always_comb begin
    rx_state_nxt  = rx_state;
    hi_byte_nxt   = hi_byte;
    cmd_nxt       = cmd;
    cmd_rdy_nxt   = cmd_rdy & ~clr_cmd_rdy;
    frame_err_nxt = 1'b0;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    case (rx_state)
      WAIT_HI: begin
        if (accept_c) begin
          hi_byte_nxt  = rx_data;
          cmd_rdy_nxt  = 1'b0;
          cnt_load     = 1'b1;
          rx_state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (accept_c) begin
          // A byte on the terminal cycle still completes the frame
          cmd_nxt      = join_bytes(hi_byte, rx_data);
          cmd_rdy_nxt  = 1'b1;
          rx_state_nxt = WAIT_HI;
        end else begin
          cnt_en = 1'b1;
          if (timeout_c) begin
            hi_byte_nxt   = '0;
            frame_err_nxt = 1'b1;
            rx_state_nxt  = WAIT_HI;
          end
        end
      end
      default: rx_state_nxt = WAIT_HI;
    endcase
  end

  // Response path: next state and registered output values
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_data_nxt   = tx_data;
    trmt_nxt      = 1'b0;
    resp_busy_nxt = resp_busy;
    case (tx_state)
      R_IDLE: begin
        if (send_resp) begin
          tx_data_nxt   = resp;
          trmt_nxt      = 1'b1;
          resp_busy_nxt = 1'b1;
          tx_state_nxt  = R_BUSY;
        end
      end
      R_BUSY: begin
        if (tx_done) begin
          resp_busy_nxt = 1'b0;
          tx_state_nxt  = R_IDLE;
        end
      end
      default: tx_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= WAIT_HI;
      tx_state   <= R_IDLE;
      hi_byte    <= '0;
      clr_rx_rdy <= 1'b0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      frame_err  <= 1'b0;
      tx_data    <= '0;
      trmt       <= 1'b0;
      resp_busy  <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      tx_state   <= tx_state_nxt;
      hi_byte    <= hi_byte_nxt;
      clr_rx_rdy <= accept_c;
      cmd        <= cmd_nxt;
      cmd_rdy    <= cmd_rdy_nxt;
      frame_err  <= frame_err_nxt;
      tx_data    <= tx_data_nxt;
      trmt       <= trmt_nxt;
      resp_busy  <= resp_busy_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed self-checking bench for cmd_frame_rx with a short inter-byte timeout.
module tb_cmd_frame_rx;
  import cmd_frame_rx_pkg::*;

  localparam int unsigned T_CLKS = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_err;
  logic [7:0]  resp;
  logic        send_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt = 0;
  int fe_cnt  = 0;

  always #5 clk = ~clk;

  cmd_frame_rx #(
    .TIMEOUT_CLKS (T_CLKS),
    .CNT_W        (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_err   (frame_err),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done),
    .resp_busy   (resp_busy)
  );

  // Pulse monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (clr_rx_rdy) clr_cnt <= clr_cnt + 1;
    if (frame_err)  fe_cnt  <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a byte until acknowledged; hold keeps rx_rdy high through the ack cycle
  task automatic send_byte(input logic [7:0] b, input bit hold, input bit clr_cmd);
    int n;
    n = 0;
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = clr_cmd;
    do begin
      @(posedge clk); #1;
      n++;
      clr_cmd_rdy = 1'b0;
    end while (!clr_rx_rdy && n < 50);
    chk("rx_ack", 32'(clr_rx_rdy), 32'd1);
    if (hold) begin
      @(posedge clk); #1;
    end
    rx_rdy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clr"},   32'(clr_rx_rdy), 32'd0);
    chk({tag, "_cmd"},   32'(cmd),        32'h0000);
    chk({tag, "_rdy"},   32'(cmd_rdy),    32'd0);
    chk({tag, "_fe"},    32'(frame_err),  32'd0);
    chk({tag, "_txd"},   32'(tx_data),    32'h00);
    chk({tag, "_trmt"},  32'(trmt),       32'd0);
    chk({tag, "_busy"},  32'(resp_busy),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_clr, base_fe, n;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    resp = 8'h00; send_resp = 1'b0; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    rst = 1'b0;
    tick();

    // Basic frame, high byte held through its ack cycle
    base_clr = clr_cnt; base_fe = fe_cnt;
    send_byte(8'h60, 1'b1, 1'b0);
    chk("hi_no_rdy", 32'(cmd_rdy), 32'd0);
    send_byte(8'h33, 1'b0, 1'b0);
    chk("f1_cmd", 32'(cmd), 32'h6033);
    chk("f1_rdy", 32'(cmd_rdy), 32'd1);
    @(negedge clk); #1;
    chk("f1_acks", 32'(clr_cnt - base_clr), 32'd2);
    chk("f1_fe", 32'(fe_cnt - base_fe), 32'd0);

    // New high byte clears cmd_rdy without touching cmd
    send_byte(8'h20, 1'b0, 1'b0);
    chk("f2_hi_rdy", 32'(cmd_rdy), 32'd0);
    chk("f2_hi_cmd", 32'(cmd), 32'h6033);
    send_byte(8'h00, 1'b0, 1'b0);
    chk("f2_cmd", 32'(cmd), 32'(CAL_GYRO));
    chk("f2_rdy", 32'(cmd_rdy), 32'd1);

    // Consumer clear
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("clr_rdy", 32'(cmd_rdy), 32'd0);
    chk("clr_cmd", 32'(cmd), 32'h2000);

    // Partial frame times out exactly T_CLKS cycles after the high-byte accept
    base_fe = fe_cnt;
    send_byte(8'h60, 1'b0, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_err && n < 200);
    chk("to_lat", 32'(n), 32'(T_CLKS));
    tick();
    chk("to_pulse", 32'(frame_err), 32'd0);
    chk("to_cmd", 32'(cmd), 32'h2000);
    chk("to_rdy", 32'(cmd_rdy), 32'd0);
    @(negedge clk); #1;
    chk("to_fe_cnt", 32'(fe_cnt - base_fe), 32'd1);

    // Realigned; low byte with simultaneous clr_cmd_rdy: set wins
    send_byte(8'h40, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b1);
    chk("f3_cmd", 32'(cmd), 32'h4011);
    chk("f3_rdy", 32'(cmd_rdy), 32'd1);

    // Low byte accepted on the terminal-count cycle
    base_fe = fe_cnt;
    send_byte(8'h60, 1'b0, 1'b0);
    repeat (T_CLKS - 1) tick();
    send_byte(8'h33, 1'b0, 1'b0);
    chk("edge_cmd", 32'(cmd), 32'h6033);
    chk("edge_rdy", 32'(cmd_rdy), 32'd1);
    repeat (3) tick();
    chk("edge_fe", 32'(fe_cnt - base_fe), 32'd0);

    // Response path
    resp = POS_ACK; send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("tx_trmt", 32'(trmt), 32'd1);
    chk("tx_data", 32'(tx_data), 32'hA5);
    chk("tx_busy", 32'(resp_busy), 32'd1);
    tick();
    chk("tx_trmt_1cyc", 32'(trmt), 32'd0);
    resp = 8'h5A; send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("tx_drop_trmt", 32'(trmt), 32'd0);
    chk("tx_drop_data", 32'(tx_data), 32'hA5);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("tx_done_busy", 32'(resp_busy), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("tx_idle_done", 32'(resp_busy), 32'd0);
    resp = 8'h3C; send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("tx2_trmt", 32'(trmt), 32'd1);
    resp = 8'h77; send_resp = 1'b1; tx_done = 1'b1;
    tick();
    send_resp = 1'b0; tx_done = 1'b0;
    chk("tx2_done_busy", 32'(resp_busy), 32'd0);
    chk("tx2_done_trmt", 32'(trmt), 32'd0);
    chk("tx2_done_data", 32'(tx_data), 32'h3C);

    // Reset mid-frame discards the high byte
    send_byte(8'h60, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst1");
    tick();
    send_byte(8'h60, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    chk("rst_f_cmd", 32'(cmd), 32'h6033);
    chk("rst_f_rdy", 32'(cmd_rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_rx.md
Name: cmd_frame_rx

Overview:
Command framing stage between the UART receiver/transmitter and the command processor in the KnightsTour DUT.
- Assembles two consecutive UART bytes, high byte first, into one 16-bit command (e.g. 0x60,0x33 -> 0x6033 "tour from (3,3)") and presents it with a ready/clear handshake.
- Serializes single-byte responses (0xA5 positive ack) back to the UART transmitter.
- Drops a half-received frame after an inter-byte timeout, so a lost byte cannot permanently misalign framing.

Parameters:
TIMEOUT_CLKS, 1_000_000, max clocks allowed between high and low byte before the high byte is discarded (20 ms at 50 MHz); must be >= 2
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CLKS

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rx_rdy  in  1  UART receiver has a byte; level, held until clr_rx_rdy is seen
rx_data  in  8  received byte, valid while rx_rdy=1
clr_rx_rdy  out  1  one-cycle pulse acknowledging the byte to the receiver
cmd  out  16  assembled command {high,low}
cmd_rdy  out  1  cmd valid; level
clr_cmd_rdy  in  1  consumer acknowledge, clears cmd_rdy
frame_err  out  1  one-cycle pulse when a partial frame times out
resp  in  8  response byte to transmit
send_resp  in  1  one-cycle request to transmit resp
tx_data  out  8  byte to UART transmitter
trmt  out  1  one-cycle start pulse to transmitter
tx_done  in  1  transmitter finished current byte
resp_busy  out  1  response in flight; send_resp ignored while high

Behaviour:
- Reset values:
  - clr_rx_rdy=0, cmd=0x0000, cmd_rdy=0, frame_err=0, tx_data=0x00, trmt=0, resp_busy=0.
  - Rx FSM enters WAIT_HI; timeout counter is 0.
  - Reset mid-frame discards the captured high byte.
- Byte accept rule:
  - A byte is accepted in any cycle with rx_rdy=1 and clr_rx_rdy=0.
  - clr_rx_rdy is registered and is high exactly the following cycle.
  - rx_rdy during a clr_rx_rdy=1 cycle is ignored, so the same byte is never captured twice.
- Rx FSM, states WAIT_HI and WAIT_LO:
  - WAIT_HI, byte accepted: store hi_byte, clear cmd_rdy, go to WAIT_LO, load counter with 0.
  - WAIT_LO, byte accepted: cmd <= {hi_byte, rx_data}, cmd_rdy <= 1, go to WAIT_HI.
    - cmd_rdy is visible the cycle after the low-byte accept cycle, i.e. 1-cycle latency.
  - WAIT_LO, no byte: counter increments each cycle.
    - On the cycle counter == TIMEOUT_CLKS-1: go to WAIT_HI, drop hi_byte, pulse frame_err for 1 cycle. cmd and cmd_rdy are unchanged.
  - Accept and timeout in the same cycle: the byte wins and is taken as the low byte; no frame_err.
- cmd_rdy clearing:
  - cleared on clr_cmd_rdy=1, or when a new high byte is accepted. The new frame overwrites; there is no queueing.
  - clr_cmd_rdy in the same cycle as a low-byte completion: set wins, cmd_rdy=1.
- cmd holds its value until the next completed frame.
- Response path, states R_IDLE and R_BUSY, independent of the Rx FSM:
  - R_IDLE with send_resp=1: tx_data <= resp, trmt=1 next cycle for exactly 1 cycle, resp_busy=1, go to R_BUSY.
  - R_BUSY: on tx_done=1, resp_busy=0, go to R_IDLE. send_resp is dropped (not queued) while in R_BUSY.
  - tx_done arriving in R_IDLE is ignored.
  - send_resp in the same cycle as tx_done in R_BUSY: ignored; the requester retries after resp_busy falls.
- Rx and Tx may operate simultaneously with no interaction.

Decomposition:
- Shared package (existing tb/RTL command package): rx_state_t {WAIT_HI, WAIT_LO}, tx_state_t {R_IDLE, R_BUSY}.
- Package constants: POS_ACK=8'hA5 and command opcodes such as CAL_GYRO, for bench use.
- One natural sub-module: frame_timeout_cnt, a loadable counter with terminal-count output parameterised by TIMEOUT_CLKS/CNT_W.
- The rest stays flat.

Test Plan:
- Bytes 0x60 then 0x33, each rx_rdy held until clr_rx_rdy -> cmd=0x6033, cmd_rdy=1 one cycle after low accept, exactly two clr_rx_rdy pulses, frame_err=0.
- cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd stays 0x6033. Then send 0x20,0x00 -> cmd=0x2000; cmd_rdy drops at the high-byte accept and rises after the low byte.
- TIMEOUT_CLKS=100: send 0x60 only, wait 100 clocks -> frame_err single pulse, FSM in WAIT_HI. Then send 0x40,0x11 -> cmd=0x4011 (no misalignment).
- Low byte arrives on exactly the timeout cycle -> cmd={hi,lo}, cmd_rdy=1, no frame_err.
- send_resp with resp=0xA5 -> tx_data=0xA5, one trmt pulse, resp_busy=1. A second send_resp while busy -> no trmt. tx_done -> resp_busy=0.
- rst=1 one cycle after a high byte is accepted -> all outputs at reset values. The next bytes 0x60,0x33 yield cmd=0x6033.
